// File: rtl/vdecode_queue_if.sv
// vdecode_queue_if: CX issue, lane issue, writeback retire and debug signals of the vector decode queue
interface vdecode_queue_if #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int VL_BITS    = 11,
   parameter int WB_PORTS   = 3,
   parameter int IDX_W      = VL_BITS
);
   localparam int BE_W = DATA_WIDTH / 8;
   localparam int CW   = $clog2(DEPTH) + 1;
   logic                           in_valid;
   logic                           in_ready;
   logic [31:0]                    in_instr;
   logic [DATA_WIDTH-1:0]          in_rs1;
   logic [DATA_WIDTH-1:0]          in_rs2;
   logic [VL_BITS-1:0]             in_vl;
   logic [VL_BITS-1:0]             in_vstart;
   logic [1:0]                     in_sew;
   logic                           flush;
   logic                           out_valid;
   logic                           out_ready;
   logic [31:0]                    out_instr;
   logic [DATA_WIDTH-1:0]          out_rs1;
   logic [DATA_WIDTH-1:0]          out_rs2;
   logic [DATA_WIDTH-1:0]          out_scalar;
   logic [IDX_W-1:0]               out_begin_idx;
   logic [IDX_W-1:0]               out_end_idx;
   logic [BE_W-1:0]                out_head_be;
   logic [BE_W-1:0]                out_tail_be;
   logic [1:0]                     out_sew;
   logic                           out_is_load;
   logic                           out_is_store;
   logic                           out_is_alu;
   logic                           out_is_cfg;
   logic                           out_uses_vs1;
   logic                           out_uses_vs2;
   logic                           out_uses_vd;
   logic                           out_vl_zero;
   logic [WB_PORTS-1:0]            wb_valid;
   logic [WB_PORTS-1:0][4:0]       wb_addr;
   logic [31:0]                    busy;
   logic [CW-1:0]                  count;
   modport slave (
      input  in_valid, in_instr, in_rs1, in_rs2, in_vl, in_vstart, in_sew, flush, out_ready, wb_valid, wb_addr,
      output in_ready, out_valid, out_instr, out_rs1, out_rs2, out_scalar, out_begin_idx, out_end_idx,
             out_head_be, out_tail_be, out_sew, out_is_load, out_is_store, out_is_alu, out_is_cfg,
             out_uses_vs1, out_uses_vs2, out_uses_vd, out_vl_zero, busy, count
   );
   modport master (
      output in_valid, in_instr, in_rs1, in_rs2, in_vl, in_vstart, in_sew, flush, out_ready, wb_valid, wb_addr,
      input  in_ready, out_valid, out_instr, out_rs1, out_rs2, out_scalar, out_begin_idx, out_end_idx,
             out_head_be, out_tail_be, out_sew, out_is_load, out_is_store, out_is_alu, out_is_cfg,
             out_uses_vs1, out_uses_vs2, out_uses_vd, out_vl_zero, busy, count
   );
endinterface

// File: rtl/vdecode_queue.sv
// vdecode_queue: in-order RVV decode FIFO with a vector-register write scoreboard gating issue
module vdecode_queue #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int VL_BITS    = 11,
   parameter int WB_PORTS   = 3,
   parameter int IDX_W      = VL_BITS
) (
   input logic             clk,
   input logic             rst,
   vdecode_queue_if.slave  q
);
   localparam int BE_W = DATA_WIDTH / 8;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int LW   = $clog2(DATA_WIDTH);
   typedef struct packed {
      logic [31:0]           instr;
      logic [DATA_WIDTH-1:0] rs1;
      logic [DATA_WIDTH-1:0] rs2;
      logic [IDX_W-1:0]      beg;
      logic [IDX_W-1:0]      fin;
      logic [BE_W-1:0]       hbe;
      logic [BE_W-1:0]       tbe;
      logic [1:0]            sew;
      logic                  ld;
      logic                  st;
      logic                  alu;
      logic                  cfg;
      logic                  vs1;
      logic                  vs2;
      logic                  vd;
      logic                  vlz;
   } entry_t;
   entry_t             r_mem [DEPTH];
   logic [AW-1:0]      r_wr, r_rd;
   logic [CW-1:0]      r_count;
   logic [31:0]        r_busy;
   entry_t             w_new, w_head;
   logic [6:0]         w_op;
   logic [2:0]         w_f3;
   logic               w_isv, w_haz, w_empty, w_full, w_enq, w_deq;
   logic [7:0]         w_sh;
   logic [VL_BITS-1:0] w_mask, w_tb, w_hb;
   logic [31:0]        w_clr, w_set;
   assign w_op   = q.in_instr[6:0];
   assign w_f3   = q.in_instr[14:12];
   assign w_isv  = w_op == 7'h57;
   // log2 of elements per word; EPW is a power of two so div/mod become shift/mask
   assign w_sh   = 8'(LW - 3) - 8'(q.in_sew);
   assign w_mask = (VL_BITS'(1) << w_sh) - VL_BITS'(1);
   assign w_tb   = (q.in_vl & w_mask) << q.in_sew;
   assign w_hb   = (q.in_vstart & w_mask) << q.in_sew;
   always_comb begin
      w_new       = '0;
      w_new.instr = q.in_instr;
      w_new.rs1   = q.in_rs1;
      w_new.rs2   = q.in_rs2;
      w_new.sew   = q.in_sew;
      w_new.cfg   = w_isv && w_f3 == 3'b111;
      w_new.ld    = w_op == 7'h07;
      w_new.st    = w_op == 7'h27;
      w_new.alu   = !w_new.cfg && !w_new.ld && !w_new.st;
      w_new.vs1   = w_isv && (w_f3 == 3'b000 || w_f3 == 3'b010);
      w_new.vs2   = w_isv && !w_new.cfg;
      w_new.vd    = w_new.vs2 || w_new.ld;
      w_new.vlz   = q.in_vl == '0;
      w_new.beg   = IDX_W'(q.in_vstart >> w_sh);
      w_new.fin   = w_new.vlz ? '0 : IDX_W'((q.in_vl - VL_BITS'(1)) >> w_sh);
      w_new.tbe   = w_tb == '0 ? '1 : (BE_W'(1) << w_tb) - BE_W'(1);
      w_new.hbe   = ~((BE_W'(1) << w_hb) - BE_W'(1));
   end
   assign w_head  = r_mem[r_rd];
   assign w_empty = r_count == '0;
   assign w_full  = r_count == CW'(DEPTH);
   // stores read their data register from the vd field, so they share the WAW check
   assign w_haz   = !w_head.cfg && ((w_head.vs1 && r_busy[w_head.instr[19:15]]) ||
                                    (w_head.vs2 && r_busy[w_head.instr[24:20]]) ||
                                    ((w_head.vd || w_head.st) && r_busy[w_head.instr[11:7]]));
   assign w_enq   = q.in_valid && !w_full && !q.flush;
   assign w_deq   = q.out_valid && q.out_ready;
   always_comb begin
      w_clr = '0;
      for (int p = 0; p < WB_PORTS; p++) if (q.wb_valid[p]) w_clr[q.wb_addr[p]] = 1'b1;
      w_set = (w_deq && w_head.vd) ? 32'(1) << w_head.instr[11:7] : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_busy  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
         if (q.flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
         end else begin
            if (w_enq) begin
               r_mem[r_wr] <= w_new;
               r_wr        <= r_wr + 1'b1;
            end
            if (w_deq) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
         end
      end
   end
   assign q.in_ready      = !w_full;
   assign q.out_valid     = !w_empty && !w_haz;
   assign q.out_instr     = w_head.instr;
   assign q.out_rs1       = w_head.rs1;
   assign q.out_rs2       = w_head.rs2;
   assign q.out_scalar    = (w_head.instr[6:0] == 7'h57 && w_head.instr[14:12] == 3'b011) ?
                            DATA_WIDTH'($signed(w_head.instr[19:15])) : w_head.rs1;
   assign q.out_begin_idx = w_head.beg;
   assign q.out_end_idx   = w_head.fin;
   assign q.out_head_be   = w_head.hbe;
   assign q.out_tail_be   = w_head.tbe;
   assign q.out_sew       = w_head.sew;
   assign q.out_is_load   = w_head.ld;
   assign q.out_is_store  = w_head.st;
   assign q.out_is_alu    = w_head.alu;
   assign q.out_is_cfg    = w_head.cfg;
   assign q.out_uses_vs1  = w_head.vs1;
   assign q.out_uses_vs2  = w_head.vs2;
   assign q.out_uses_vd   = w_head.vd;
   assign q.out_vl_zero   = w_head.vlz;
   assign q.busy          = r_busy;
   assign q.count         = r_count;
endmodule

// File: tb/tb_vdecode_queue.sv
// tb_vdecode_queue: scoreboard bench for vdecode_queue; a decode model feeds expected entries to a queue
module tb_vdecode_queue;
   localparam int DW = 64;
   localparam int DEPTH = 4;
   localparam int VLB = 11;
   localparam int WBP = 3;
   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] scalar;
      logic [10:0] beg;
      logic [10:0] fin;
      logic [7:0]  hbe;
      logic [7:0]  tbe;
      logic [1:0]  sew;
      logic [7:0]  flags;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fails = 0;
   exp_t exp_q[$];
   logic [31:0] m_busy = '0;
   always #5 clk = ~clk;
   vdecode_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .VL_BITS(VLB), .WB_PORTS(WBP)) q();
   vdecode_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .VL_BITS(VLB), .WB_PORTS(WBP)) dut (
      .clk(clk), .rst(rst), .q(q)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] vop(input logic [2:0] f3, input int vd, input int vs1, input int vs2);
      return {6'd0, 1'b1, 5'(vs2), 5'(vs1), f3, 5'(vd), 7'h57};
   endfunction
   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                                  input int vl, input int vs, input int sew);
      exp_t e;
      int epw, tb, hb;
      logic isv, cfg, ld, st, alu;
      logic [2:0] f3;
      f3  = ins[14:12];
      isv = ins[6:0] == 7'b1010111;
      cfg = isv && f3 == 3'b111;
      ld  = ins[6:0] == 7'b0000111;
      st  = ins[6:0] == 7'b0100111;
      alu = (isv && !cfg) || (!isv && !ld && !st);
      epw = DW / (8 << sew);
      tb  = (vl % epw) * (1 << sew);
      hb  = (vs % epw) * (1 << sew);
      e.instr  = ins;
      e.rs1    = r1;
      e.rs2    = r2;
      e.scalar = (isv && f3 == 3'b011) ? 64'($signed(ins[19:15])) : r1;
      e.beg    = 11'(vs / epw);
      e.fin    = (vl == 0) ? 11'd0 : 11'((vl - 1) / epw);
      e.tbe    = (tb == 0) ? 8'hFF : 8'((1 << tb) - 1);
      e.hbe    = ~8'((1 << hb) - 1);
      e.sew    = 2'(sew);
      e.flags  = {ld, st, alu, cfg, isv && !cfg && (f3 == 3'b000 || f3 == 3'b010),
                  isv && !cfg, (isv && !cfg) || ld, vl == 0};
      return e;
   endfunction
   // monitor: busy model, in-order compare of issued entries, push of accepted ones
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] nb;
      if (rst) begin
         m_busy = '0;
         exp_q.delete();
      end else begin
         check("busy", q.busy, m_busy);
         nb = m_busy;
         for (int p = 0; p < WBP; p++) if (q.wb_valid[p]) nb[q.wb_addr[p]] = 1'b0;
         if (q.out_valid && q.out_ready) begin
            if (exp_q.size() == 0) check("spurious_issue", q.out_valid, 0);
            else begin
               e = exp_q.pop_front();
               check("instr", q.out_instr, e.instr);
               check("rs1", q.out_rs1, e.rs1);
               check("rs2", q.out_rs2, e.rs2);
               check("scalar", q.out_scalar, e.scalar);
               check("idx", {q.out_begin_idx, q.out_end_idx}, {e.beg, e.fin});
               check("be", {q.out_head_be, q.out_tail_be}, {e.hbe, e.tbe});
               check("sew", q.out_sew, e.sew);
               check("flags", {q.out_is_load, q.out_is_store, q.out_is_alu, q.out_is_cfg, q.out_uses_vs1,
                               q.out_uses_vs2, q.out_uses_vd, q.out_vl_zero}, e.flags);
               if (e.flags[1]) nb[e.instr[11:7]] = 1'b1;
            end
         end
         if (q.flush) exp_q.delete();
         else if (q.in_valid && q.in_ready)
            exp_q.push_back(model(q.in_instr, q.in_rs1, q.in_rs2, int'(q.in_vl), int'(q.in_vstart), int'(q.in_sew)));
         m_busy = nb;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] ins, input int vl, input int vs, input int sew);
      q.in_valid  = 1'b1;
      q.in_instr  = ins;
      q.in_rs1    = {$urandom, $urandom};
      q.in_rs2    = {$urandom, $urandom};
      q.in_vl     = VLB'(vl);
      q.in_vstart = VLB'(vs);
      q.in_sew    = 2'(sew);
      tick();
      q.in_valid  = 1'b0;
   endtask
   task automatic issue();
      q.out_ready = 1'b1;
      tick();
      q.out_ready = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [31:0] ld, st;
      int n;
      q.in_valid = 0; q.in_instr = 0; q.in_rs1 = 0; q.in_rs2 = 0; q.in_vl = 0; q.in_vstart = 0;
      q.in_sew = 0; q.flush = 0; q.out_ready = 0; q.wb_valid = 0; q.wb_addr = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_count", q.count, 0);
      check("rst_in_ready", q.in_ready, 1);
      check("rst_out_valid", q.out_valid, 0);
      check("rst_busy", q.busy, 0);
      check("rst_data", {q.out_instr, q.out_head_be, q.out_tail_be, q.out_end_idx}, 0);
      check("rst_scalar", q.out_scalar, 0);
      // vadd.vv v3,v1,v2, sew=8, vl=13
      drive(vop(3'b000, 3, 1, 2), 13, 0, 0);
      check("t1_valid", q.out_valid, 1);
      check("t1_idx", {q.out_begin_idx, q.out_end_idx}, {11'd0, 11'd1});
      check("t1_be", {q.out_head_be, q.out_tail_be}, 16'hFF1F);
      check("t1_uses", {q.out_uses_vs1, q.out_uses_vs2, q.out_uses_vd}, 3'b111);
      issue();
      check("t1_busy", q.busy, 32'h8);
      // RAW on v3 held until retire on port 1
      q.out_ready = 1'b1;
      drive(vop(3'b000, 4, 1, 3), 8, 0, 0);
      check("t2_stall0", q.out_valid, 0);
      tick();
      check("t2_stall1", q.out_valid, 0);
      q.wb_valid = 3'b010; q.wb_addr[1] = 5'd3;
      check("t2_stall_wb", q.out_valid, 0);
      tick();
      q.wb_valid = 3'b000;
      check("t2_release", q.out_valid, 1);
      tick();
      q.out_ready = 1'b0;
      check("t2_busy", q.busy, 32'h10);
      ld = {7'd0, 5'd0, 5'd1, 3'b000, 5'd7, 7'h07};
      drive(ld, 4, 3, 2);
      check("t3_valid", q.out_valid, 1);
      check("t3_idx", {q.out_begin_idx, q.out_end_idx}, {11'd1, 11'd1});
      check("t3_be", {q.out_head_be, q.out_tail_be}, 16'hF0FF);
      check("t3_load", q.out_is_load, 1);
      issue();
      st = {7'd0, 5'd0, 5'd1, 3'b110, 5'd7, 7'h27};
      drive(st, 0, 0, 1);
      check("t3_store_stall", q.out_valid, 0);
      check("t3_vl_zero", {q.out_vl_zero, q.out_end_idx}, {1'b1, 11'd0});
      q.wb_valid = 3'b101; q.wb_addr[0] = 5'd4; q.wb_addr[2] = 5'd7;
      tick();
      q.wb_valid = 3'b000;
      check("t3_store_go", {q.out_valid, q.out_is_store}, 2'b11);
      issue();
      drive(vop(3'b011, 8, 5'b11101, 9), 20, 5, 1);
      check("t3_simm", q.out_scalar, 64'hFFFF_FFFF_FFFF_FFFD);
      check("t3_simm_be", {q.out_head_be, q.out_tail_be, q.out_end_idx}, {8'hFC, 8'hFF, 11'd4});
      issue();
      drive({7'd0, 5'd8, 5'd8, 3'b111, 5'd8, 7'h57}, 1, 0, 0);
      check("t3_cfg", {q.out_valid, q.out_is_cfg}, 2'b11);
      issue();
      drive({7'd0, 5'd8, 5'd8, 3'b000, 5'd8, 7'h33}, 1, 0, 0);
      check("t3_other", {q.out_valid, q.out_is_alu, q.out_uses_vs1, q.out_uses_vs2, q.out_uses_vd}, 5'b11000);
      issue();
      q.wb_valid = 3'b001; q.wb_addr[0] = 5'd8;
      tick();
      q.wb_valid = 3'b000;
      // fill, full rejects even with a concurrent issue, then steady-state streaming across wrap
      for (int k = 0; k < DEPTH; k++) drive(vop(3'b000, 10 + k, 24 + k, 28 + k), 8 + k * 5, k, k % 4);
      check("t4_count_full", q.count, DEPTH);
      check("t4_in_ready_full", q.in_ready, 0);
      q.in_valid = 1'b1; q.in_instr = vop(3'b000, 30, 24, 28); q.out_ready = 1'b1;
      tick();
      q.in_valid = 1'b0; q.out_ready = 1'b0;
      check("t4_count_deq", q.count, DEPTH - 1);
      check("t4_in_ready_deq", q.in_ready, 1);
      q.out_ready = 1'b1;
      for (int k = 4; k < 10; k++) begin
         drive(vop(3'b000, 10 + k, 24 + k % 4, 28 + k % 4), 8 + k * 5, k, k % 4);
         check("t4_steady_count", q.count, DEPTH - 1);
      end
      n = 0;
      while (q.count != 0 && n < 20) begin tick(); n++; end
      q.out_ready = 1'b0;
      check("t4_drained", q.count, 0);
      check("t4_busy", q.busy, 32'h000F_FC00);
      for (int r = 10; r < 20; r += 3) begin
         q.wb_valid = 3'b111; q.wb_addr[0] = 5'(r); q.wb_addr[1] = 5'(r + 1); q.wb_addr[2] = 5'(r + 2);
         tick();
      end
      q.wb_valid = 3'b000;
      check("t4_busy_clr", q.busy, 0);
      // set beats clear on the same register
      drive(vop(3'b010, 5, 24, 28), 8, 0, 0);
      issue();
      drive(vop(3'b000, 5, 25, 29), 8, 0, 0);
      check("t5_waw_stall", q.out_valid, 0);
      q.wb_valid = 3'b111; q.wb_addr[0] = 5'd5; q.wb_addr[1] = 5'd5; q.wb_addr[2] = 5'd5;
      tick();
      q.wb_valid = 3'b001;
      check("t5_release", q.out_valid, 1);
      issue();
      q.wb_valid = 3'b000;
      check("t5_set_wins", q.busy, 32'h20);
      q.wb_valid = 3'b001;
      tick();
      q.wb_valid = 3'b000;
      // flush with 3 queued, concurrent enqueue and issue
      for (int k = 0; k < 3; k++) drive(vop(3'b000, 1 + k, 24, 28), 8, 0, 0);
      check("t6_count3", q.count, 3);
      q.flush = 1'b1; q.in_valid = 1'b1; q.in_instr = vop(3'b000, 6, 24, 28); q.out_ready = 1'b1;
      tick();
      q.flush = 1'b0; q.in_valid = 1'b0; q.out_ready = 1'b0;
      check("t6_count0", q.count, 0);
      check("t6_valid0", q.out_valid, 0);
      check("t6_busy", q.busy, 32'h2);
      tick();
      check("t6_dropped", {q.out_valid, q.count}, 0);
      drive(vop(3'b000, 9, 24, 28), 16, 2, 3);
      check("t6_after", q.out_valid, 1);
      issue();
      tick();
      check("t6_busy_end", q.busy, 32'h202);
      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/vdecode_queue.md
# vdecode_queue

Parametrised in-order vector instruction decode queue with register scoreboard. It sits between the scalar-core CX issue interface and the vector lanes, and decodes each accepted instruction into bank indices, byte enables and operand-use flags. Decoded entries are buffered in a DEPTH-entry FIFO. An entry issues to the lanes only when none of its vector registers has an outstanding write.

## Interface

Parameters:
- DATA_WIDTH, 64: lane word width in bits; power of two, ≥64. BE_W = DATA_WIDTH/8.
- DEPTH, 4: queue entries; power of two, ≥2.
- VL_BITS, 11: width of vl/vstart.
- WB_PORTS, 3: number of writeback-retire ports clearing the scoreboard.
- IDX_W, VL_BITS: width of begin_idx/end_idx.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; synchronous, active-high.
- in_valid, input, 1: instruction offered.
- in_ready, output, 1: queue can accept; equals !full.
- in_instr, input, 32: RVV instruction.
- in_rs1, input, DATA_WIDTH: scalar operand 1.
- in_rs2, input, DATA_WIDTH: scalar operand 2.
- in_vl, input, VL_BITS: vector length at enqueue.
- in_vstart, input, VL_BITS: vstart at enqueue.
- in_sew, input, 2: element width code, 8<<sew bits.
- flush, input, 1: discard all queued entries.
- out_valid, output, 1: head entry issuable.
- out_ready, input, 1: lanes accept head.
- out_instr, output, 32: instruction of head entry.
- out_rs1, output, DATA_WIDTH: rs1 of head entry.
- out_rs2, output, DATA_WIDTH: rs2 of head entry.
- out_scalar, output, DATA_WIDTH: OPIVI imm[19:15] sign-extended, else rs1.
- out_begin_idx, output, IDX_W: first word index.
- out_end_idx, output, IDX_W: last word index.
- out_head_be, output, BE_W: byte enable for the first word.
- out_tail_be, output, BE_W: byte enable for the last word.
- out_sew, output, 2: SEW of head entry.
- out_is_load, output, 1: load class.
- out_is_store, output, 1: store class.
- out_is_alu, output, 1: ALU class.
- out_is_cfg, output, 1: vset* class.
- out_uses_vs1, output, 1: reads vs1.
- out_uses_vs2, output, 1: reads vs2.
- out_uses_vd, output, 1: writes vd.
- out_vl_zero, output, 1: vl was 0 at enqueue.
- wb_valid, input, WB_PORTS: per-port retire strobe.
- wb_addr, input, WB_PORTS×5: vd retired on each port.
- busy, output, 32: scoreboard, for debug.
- count, output, $clog2(DEPTH)+1: occupancy.

## Operation

Class decode, from in_instr:
- opcode 1010111 with funct3 111: cfg.
- opcode 1010111 with any other funct3: alu.
- opcode 0000111: load.
- opcode 0100111: store.
- Any other opcode: treated as alu with all use flags 0.

Use flags:
- uses_vs1: alu with funct3 ∈ {000, 010}.
- uses_vs2: alu.
- uses_vd: alu or load.
- A store reads field [11:7] as its source (vs3).

Index and byte-enable arithmetic, with EPW = DATA_WIDTH/(8<<sew):
- begin_idx = vstart / EPW.
- end_idx = (vl−1) / EPW. If vl=0, end_idx=0 and vl_zero=1.
- tb = (vl mod EPW)·(1<<sew). tail_be = all-ones if tb=0, else (1<<tb)−1.
- hb = (vstart mod EPW)·(1<<sew). head_be = ~((1<<hb)−1).

Decode happens at enqueue. All decoded fields are stored per entry in the FIFO.

Hazard check on the head entry:
- Check busy[vs1] if uses_vs1, busy[vs2] if uses_vs2, and busy[vd] if uses_vd (WAW) or if store.
- out_valid = !empty && no hazard. cfg entries never check the scoreboard.

Scoreboard:
- Issue (out_valid && out_ready) of a uses_vd entry sets busy[vd].
- wb_valid[p] clears busy[wb_addr[p]].
- A set and a clear of the same register in the same cycle: set wins.
- Multiple ports clearing the same register is legal.

Flush:
- Empties the FIFO: pointers and count go to 0, and out_valid is low the next cycle.
- busy is untouched.
- Enqueue in the flush cycle is dropped.
- An issue in the flush cycle still completes and sets busy.

## Timing

- Reset: empty, count=0, busy=0, in_ready=1, out_valid=0, all out_* data = 0.
- Latency: an instruction enqueued in cycle N appears at the head with out_valid in cycle N+1 at the earliest.
- in_ready = !full. A full queue does not accept, even if the head issues in the same cycle.
- Simultaneous enqueue and dequeue on a non-full, non-empty queue: count unchanged.
- A retire in cycle N makes a stalled head valid in cycle N+1 (busy is registered).
- out_* data is stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH.

## Test plan

- Enqueue vadd.vv v3,v1,v2 (funct3 000), sew=0, vl=13, vstart=0, DATA_WIDTH=64. Expect next cycle: out_valid=1, begin_idx=0, end_idx=1, tail_be=0x1F, head_be=0xFF, uses_vs1/vs2/vd=1.
- Issue a write to v3, then enqueue a reader of v3 as vs2. Expect out_valid=0 until wb_valid[1]=1 with wb_addr=3, and out_valid=1 one cycle later.
- sew=2, vstart=3, vl=4 at DATA_WIDTH=64. Expect begin_idx=1, head_be=0xF0, end_idx=1, tail_be=0xFF.
- Hold out_ready=0 and enqueue DEPTH entries. Expect in_ready=0 and count=DEPTH. One dequeue, then in_ready=1 the next cycle, with FIFO order preserved across wrap.
- With busy[5] set, retire v5 and issue a new writer of v5 in the same cycle. Expect busy[5]=1.
- Assert flush with 3 queued entries and a concurrent in_valid. Expect count=0 and out_valid=0 next cycle, busy unchanged, and the concurrent instruction not enqueued.
